// File: rtl/i2c_target.sv
// 7-bit-address I2C target: synchronizes SCL/SDA, detects START/STOP, ACKs its address,
// strobes out received bytes and serves read bytes from a host-side valid/ack handshake.
module i2c_target #(
    parameter logic [6:0] TARGET_ADDR = 7'h44,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       Scl_In,
    input  logic       Sda_In,
    output logic       Sda_Pull_Low,
    output logic [7:0] Rx_Data,
    output logic       Rx_Valid,
    input  logic [7:0] Tx_Data,
    input  logic       Tx_Valid,
    output logic       Tx_Ack,
    output logic       Start_Det,
    output logic       Stop_Det,
    output logic       Busy,
    output logic [2:0] Target_State_Out
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        ADDR_ACK = 3'd2,
        RX       = 3'd3,
        RX_ACK   = 3'd4,
        TX       = 3'd5,
        TX_ACK   = 3'd6
    } state_e;

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_prev_q, sda_prev_q;

    state_e     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] tx_sr_q, tx_sr_d;
    logic       rw_q, rw_d;
    logic       pull_q, pull_d;
    logic       busy_q, busy_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_ack_q, tx_ack_d;
    logic       start_det_q, start_det_d;
    logic       stop_det_q, stop_det_d;

    logic       scl, sda, scl_rise, scl_fall, start_cond, stop_cond;
    logic [7:0] tx_byte;

    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], Scl_In};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], Sda_In};
        scl        = scl_sync_q[SYNC_STAGES-1];
        sda        = sda_sync_q[SYNC_STAGES-1];
        scl_rise   = scl & ~scl_prev_q;
        scl_fall   = ~scl & scl_prev_q;
        start_cond = scl & sda_prev_q & ~sda;
        stop_cond  = scl & ~sda_prev_q & sda;
        // An empty host FIFO reads as all-ones, i.e. SDA left released.
        tx_byte    = Tx_Valid ? Tx_Data : 8'hFF;
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        tx_sr_d     = tx_sr_q;
        rw_d        = rw_q;
        pull_d      = pull_q;
        busy_d      = busy_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        tx_ack_d    = 1'b0;
        start_det_d = 1'b0;
        stop_det_d  = 1'b0;

        if (start_cond) begin
            start_det_d = 1'b1;
            pull_d      = 1'b0;
            busy_d      = 1'b0;
            bit_cnt_d   = 4'd0;
            state_d     = ADDR;
        end else if (stop_cond) begin
            stop_det_d = 1'b1;
            pull_d     = 1'b0;
            busy_d     = 1'b0;
            bit_cnt_d  = 4'd0;
            state_d    = IDLE;
        end else begin
            unique case (state_q)
                ADDR: begin
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        shift_d   = {shift_q[6:0], sda};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        bit_cnt_d = 4'd0;
                        if (shift_q[7:1] == TARGET_ADDR) begin
                            pull_d  = 1'b1;
                            busy_d  = 1'b1;
                            rw_d    = shift_q[0];
                            state_d = ADDR_ACK;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_d = 4'd0;
                        if (!rw_q) begin
                            pull_d  = 1'b0;
                            state_d = RX;
                        end else begin
                            tx_sr_d  = tx_byte;
                            tx_ack_d = Tx_Valid;
                            pull_d   = ~tx_byte[7];
                            state_d  = TX;
                        end
                    end
                end
                RX: begin
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        shift_d   = {shift_q[6:0], sda};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                        pull_d     = 1'b1;
                        state_d    = RX_ACK;
                    end
                end
                RX_ACK: begin
                    if (scl_fall) begin
                        pull_d    = 1'b0;
                        bit_cnt_d = 4'd0;
                        state_d   = RX;
                    end
                end
                TX: begin
                    // bit_cnt counts bits already shifted out after the MSB
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd7) begin
                            pull_d    = 1'b0;
                            bit_cnt_d = 4'd0;
                            state_d   = TX_ACK;
                        end else begin
                            tx_sr_d   = {tx_sr_q[6:0], 1'b1};
                            pull_d    = ~tx_sr_q[6];
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                TX_ACK: begin
                    if (scl_rise) begin
                        if (sda) begin
                            pull_d  = 1'b0;
                            busy_d  = 1'b0;
                            state_d = IDLE;
                        end else begin
                            bit_cnt_d = 4'd1;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd1) begin
                        tx_sr_d   = tx_byte;
                        tx_ack_d  = Tx_Valid;
                        pull_d    = ~tx_byte[7];
                        bit_cnt_d = 4'd0;
                        state_d   = TX;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q  <= '1;
            sda_sync_q  <= '1;
            scl_prev_q  <= 1'b1;
            sda_prev_q  <= 1'b1;
            state_q     <= IDLE;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 8'd0;
            tx_sr_q     <= 8'd0;
            rw_q        <= 1'b0;
            pull_q      <= 1'b0;
            busy_q      <= 1'b0;
            rx_data_q   <= 8'd0;
            rx_valid_q  <= 1'b0;
            tx_ack_q    <= 1'b0;
            start_det_q <= 1'b0;
            stop_det_q  <= 1'b0;
        end else begin
            scl_sync_q  <= scl_sync_d;
            sda_sync_q  <= sda_sync_d;
            scl_prev_q  <= scl;
            sda_prev_q  <= sda;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tx_sr_q     <= tx_sr_d;
            rw_q        <= rw_d;
            pull_q      <= pull_d;
            busy_q      <= busy_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            tx_ack_q    <= tx_ack_d;
            start_det_q <= start_det_d;
            stop_det_q  <= stop_det_d;
        end
    end

    assign Sda_Pull_Low     = pull_q;
    assign Rx_Data          = rx_data_q;
    assign Rx_Valid         = rx_valid_q;
    assign Tx_Ack           = tx_ack_q;
    assign Start_Det        = start_det_q;
    assign Stop_Det         = stop_det_q;
    assign Busy             = busy_q;
    assign Target_State_Out = state_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bit-banged I2C master driving i2c_target over a wired-AND SDA line, with a
// transaction-level expectation model and randomized write/read traffic.
module tb_i2c_target;
    localparam int         SS   = 2;
    localparam logic [6:0] ADDR = 7'h44;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       pull, rx_valid, tx_ack, start_det, stop_det, busy;
    logic [7:0] rx_data;
    logic [2:0] st;
    logic       sda_bus;

    assign sda_bus = sda_m & ~pull;
    always #5 clk = ~clk;

    i2c_target #(.TARGET_ADDR(ADDR), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rst_n(rst_n), .Scl_In(scl_m), .Sda_In(sda_bus),
        .Sda_Pull_Low(pull), .Rx_Data(rx_data), .Rx_Valid(rx_valid),
        .Tx_Data(tx_data), .Tx_Valid(tx_valid), .Tx_Ack(tx_ack),
        .Start_Det(start_det), .Stop_Det(stop_det), .Busy(busy),
        .Target_State_Out(st)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bus-event monitor
    int         n_start = 0, n_stop = 0, n_txack = 0, strobe_bad = 0;
    logic       pull_seen = 1'b0;
    logic [3:0] prev_strb = 4'd0;
    logic [7:0] rx_q[$];

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (rx_valid) rx_q.push_back(rx_data);
            if (tx_ack) n_txack++;
            if (start_det) n_start++;
            if (stop_det) n_stop++;
            if (pull) pull_seen = 1'b1;
            if (({rx_valid, tx_ack, start_det, stop_det} & prev_strb) != 4'd0) strobe_bad++;
        end
        prev_strb = {rx_valid, tx_ack, start_det, stop_det};
    end

    // SDA reaction latency measured from the pin-level SCL fall
    int   since = 0, lat_n = 0, lat_bad = 0;
    logic scl_p = 1'b1, pull_p = 1'b0;

    initial forever begin
        @(posedge clk);
        since = (scl_p && !scl_m) ? 1 : since + 1;
        scl_p = scl_m;
        #1;
        if (rst_n && pull !== pull_p) begin
            lat_n++;
            if (since != SS + 1) lat_bad++;
        end
        pull_p = pull;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    // Master primitives: one bit = 16 clk, SDA changes mid-low, sampled mid-high
    task automatic wait_q();
        repeat (4) @(negedge clk);
    endtask

    task automatic clock_bit(input logic b, output logic s);
        wait_q(); sda_m = b;
        wait_q(); scl_m = 1'b1;
        wait_q(); s = sda_bus;
        wait_q(); scl_m = 1'b0;
    endtask

    task automatic bus_start();
        if (!scl_m) begin
            wait_q(); sda_m = 1'b1;
            wait_q(); scl_m = 1'b1;
        end
        wait_q(); sda_m = 1'b0;
        wait_q(); scl_m = 1'b0;
    endtask

    task automatic bus_stop();
        wait_q(); sda_m = 1'b0;
        wait_q(); scl_m = 1'b1;
        wait_q(); sda_m = 1'b1;
        wait_q(); wait_q();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
        clock_bit(1'b1, s);
        ack = ~s;
    endtask

    // Next host byte is presented during this byte's ACK clock, ahead of its load
    task automatic read_byte(input logic do_ack, input logic nv, input logic [7:0] nd,
                             output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, s);
            b[i] = s;
        end
        tx_valid = nv;
        tx_data  = nd;
        clock_bit(~do_ack, s);
    endtask

    logic [7:0] wbuf[4];
    logic [7:0] tbuf[4];
    logic       tvld[4];

    task automatic run_write(input logic [6:0] a, input int n, input string tag);
        logic ack, match;
        int   s0, p0;
        match = (a == ADDR);
        pull_seen = 1'b0;
        rx_q.delete();
        s0 = n_start; p0 = n_stop;
        bus_start();
        write_byte({a, 1'b0}, ack);
        chk({tag, "_aack"}, ack, match);
        if (match) chk({tag, "_busy"}, busy, 1);
        else chk({tag, "_st9"}, st, 0);
        for (int k = 0; k < n; k++) begin
            write_byte(wbuf[k], ack);
            chk($sformatf("%s_dack%0d", tag, k), ack, match);
        end
        bus_stop();
        chk({tag, "_nrx"}, rx_q.size(), match ? n : 0);
        for (int k = 0; k < n && k < rx_q.size(); k++)
            chk($sformatf("%s_rx%0d", tag, k), rx_q[k], wbuf[k]);
        if (!match) chk({tag, "_nopull"}, pull_seen, 0);
        chk({tag, "_nstart"}, n_start - s0, 1);
        chk({tag, "_nstop"}, n_stop - p0, 1);
        chk({tag, "_st"}, st, 0);
        chk({tag, "_busy0"}, busy, 0);
    endtask

    task automatic run_read(input logic [6:0] a, input int n, input string tag);
        logic       ack, match, nv;
        logic [7:0] b, nd;
        int         t0, exp_ack;
        match = (a == ADDR);
        pull_seen = 1'b0;
        t0 = n_txack;
        exp_ack = 0;
        tx_valid = tvld[0];
        tx_data  = tbuf[0];
        bus_start();
        write_byte({a, 1'b1}, ack);
        chk({tag, "_aack"}, ack, match);
        for (int k = 0; k < n; k++) begin
            nv = (k + 1 < n) ? tvld[k+1] : 1'b0;
            nd = (k + 1 < n) ? tbuf[k+1] : 8'h00;
            read_byte(k != n - 1, nv, nd, b);
            if (match) begin
                chk($sformatf("%s_byte%0d", tag, k), b, tvld[k] ? tbuf[k] : 8'hFF);
                if (tvld[k]) exp_ack++;
            end
        end
        chk({tag, "_st_nack"}, st, 0);
        chk({tag, "_busy_nack"}, busy, 0);
        bus_stop();
        tx_valid = 1'b0;
        chk({tag, "_ntxack"}, n_txack - t0, exp_ack);
        if (!match) chk({tag, "_nopull"}, pull_seen, 0);
    endtask

    task automatic run_rep(input logic [7:0] d, input logic [7:0] t, input string tag);
        logic       ack;
        logic [7:0] b;
        int         s0, t0;
        rx_q.delete();
        s0 = n_start; t0 = n_txack;
        bus_start();
        write_byte({ADDR, 1'b0}, ack);
        write_byte(d, ack);
        chk({tag, "_wack"}, ack, 1);
        bus_start();
        chk({tag, "_st_rs"}, st, 1);
        chk({tag, "_busy_rs"}, busy, 0);
        tx_valid = 1'b1;
        tx_data  = t;
        write_byte({ADDR, 1'b1}, ack);
        chk({tag, "_raack"}, ack, 1);
        read_byte(1'b0, 1'b0, 8'h00, b);
        chk({tag, "_rbyte"}, b, t);
        bus_stop();
        tx_valid = 1'b0;
        chk({tag, "_nstart"}, n_start - s0, 2);
        chk({tag, "_nrx"}, rx_q.size(), 1);
        if (rx_q.size() > 0) chk({tag, "_rx"}, rx_q[0], d);
        chk({tag, "_ntxack"}, n_txack - t0, 1);
    endtask

    task automatic run_reset_mid(input string tag);
        logic ack;
        tx_valid = 1'b1;
        tx_data  = 8'h00;
        bus_start();
        write_byte({ADDR, 1'b1}, ack);
        wait_q();
        chk({tag, "_pull_pre"}, pull, 1);
        #2 rst_n = 1'b0;
        #1;
        chk({tag, "_pull"}, pull, 0);
        chk({tag, "_st"}, st, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_rxd"}, rx_data, 0);
        tx_valid = 1'b0;
        @(negedge clk); sda_m = 1'b1;
        wait_q(); scl_m = 1'b1;
        wait_q(); rst_n = 1'b1;
        wait_q();
        wbuf[0] = 8'h5A;
        run_write(ADDR, 1, {tag, "_after"});
    endtask

    initial begin
        int         kind, n;
        logic [6:0] a;

        repeat (5) @(negedge clk);
        chk("rst_pull", pull, 0);
        chk("rst_st", st, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rxd", rx_data, 0);
        chk("rst_rxv", rx_valid, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        wbuf[0] = 8'hFD;
        run_write(ADDR, 1, "wr");
        run_write(7'h45, 1, "wrong");
        tbuf[0] = 8'h66; tvld[0] = 1'b1;
        tbuf[1] = 8'hA3; tvld[1] = 1'b1;
        run_read(ADDR, 2, "rd");
        run_rep(8'hFD, 8'h3C, "rep");
        tbuf[0] = 8'h12; tvld[0] = 1'b0;
        run_read(ADDR, 1, "under");
        run_reset_mid("rstmid");

        for (int it = 0; it < 16; it++) begin
            kind = $urandom_range(0, 3);
            n    = $urandom_range(1, 3);
            for (int k = 0; k < 4; k++) begin
                wbuf[k] = 8'($urandom);
                tbuf[k] = 8'($urandom);
                tvld[k] = 1'($urandom_range(0, 1));
            end
            a = 7'($urandom_range(0, 127));
            if (a == ADDR) a = a + 7'd1;
            case (kind)
                0: run_write(ADDR, n, $sformatf("rw%0d", it));
                1: run_write(a, n, $sformatf("rwx%0d", it));
                2: run_read(ADDR, n, $sformatf("rr%0d", it));
                default: run_read(a, 1, $sformatf("rrx%0d", it));
            endcase
        end

        chk("strobe_width", strobe_bad, 0);
        chk("sda_latency", lat_bad, 0);
        chk("latency_seen", lat_n != 0, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
